// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types, status codes and width helpers for the matmul sequencer and engine
//
// Contents:
//   state_e      : sequencer states (IDLE=0, RUN=1, DONE=2)
//   status_e     : result status codes (00 ok, 01 bad dims, 10 timeout)
//   DIM_WIDTH    : width of each dimension field
//   calc_*       : MAX_DIM and packed operand/result/flag widths from DATA_WIDTH/BUS_WIDTH
//   dim_invalid  : true when a dimension is zero or larger than MAX_DIM
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STATUS_OK       = 2'b00,
    STATUS_BAD_DIMS = 2'b01,
    STATUS_TIMEOUT  = 2'b10
  } status_e;

  localparam int DIM_WIDTH = 3;

  function automatic int calc_max_dim(int bus_w, int data_w);
    return bus_w / data_w;
  endfunction

  function automatic int calc_mat_width(int bus_w, int data_w);
    return calc_max_dim(bus_w, data_w) * calc_max_dim(bus_w, data_w) * data_w;
  endfunction

  // Products are double width, so the result matrix is twice the operand width.
  function automatic int calc_res_width(int bus_w, int data_w);
    return 2 * calc_mat_width(bus_w, data_w);
  endfunction

  function automatic int calc_flag_width(int bus_w, int data_w);
    return calc_max_dim(bus_w, data_w) * calc_max_dim(bus_w, data_w);
  endfunction

  function automatic logic dim_invalid(logic [DIM_WIDTH-1:0] dim, int max_dim);
    return (dim == '0) || (int'(dim) > max_dim);
  endfunction

endpackage

// File: rtl/matmul_watchdog.sv
// rtl/matmul_watchdog.sv - saturating run-cycle counter with timeout compare
//
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : zero the counter (held while the sequencer is idle)
//   en_i           : count this cycle (sequencer in RUN)
//   count_next_o   : count value including the current cycle, saturating at all-ones
//   expired_o      : the current enabled cycle brings the count to TIMEOUT
module matmul_watchdog
  import matmul_pkg::*;
#(
  parameter int TIMEOUT   = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] count_next_o,
  output logic                 expired_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // The next value is exported so the sequencer can record the count
  // that includes the cycle on which it leaves RUN.
  assign cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign count_next_o = cnt_d;
  assign expired_o    = en_i && (int'(cnt_d) >= TIMEOUT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matmul_ctrl_fsm.sv
// rtl/matmul_ctrl_fsm.sv - command-level sequencer for the systolic matmul engine
//
// Ports:
//   clk_i, rst_ni                    : clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o        : command handshake (dims + packed A/B)
//   n_dim_i, k_dim_i, m_dim_i        : A is NxK, B is KxM
//   a_matrix_i, b_matrix_i           : packed operands
//   eng_start_o, eng_*_dim_o         : start bit and latched dims to engine
//   eng_a_matrix_o, eng_b_matrix_o   : latched operands to engine
//   eng_finish_i, eng_c_matrix_i,
//   eng_flags_i                      : engine completion, result, overflow flags
//   res_valid_o / res_ready_i        : held-result handshake
//   c_matrix_o, flags_o, status_o,
//   cycles_o                         : captured result, flags, status, RUN cycle count
//   busy_o                           : sequencer not idle
module matmul_ctrl_fsm
  import matmul_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  BUS_WIDTH  = 16,
  parameter int  TIMEOUT    = 32,
  parameter int  CNT_WIDTH  = 8,
  localparam int MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int MAT_W      = calc_mat_width(BUS_WIDTH, DATA_WIDTH),
  localparam int RES_W      = calc_res_width(BUS_WIDTH, DATA_WIDTH),
  localparam int FLG_W      = calc_flag_width(BUS_WIDTH, DATA_WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [DIM_WIDTH-1:0] n_dim_i,
  input  logic [DIM_WIDTH-1:0] k_dim_i,
  input  logic [DIM_WIDTH-1:0] m_dim_i,
  input  logic [MAT_W-1:0]     a_matrix_i,
  input  logic [MAT_W-1:0]     b_matrix_i,
  output logic                 eng_start_o,
  output logic [DIM_WIDTH-1:0] eng_n_dim_o,
  output logic [DIM_WIDTH-1:0] eng_k_dim_o,
  output logic [DIM_WIDTH-1:0] eng_m_dim_o,
  output logic [MAT_W-1:0]     eng_a_matrix_o,
  output logic [MAT_W-1:0]     eng_b_matrix_o,
  input  logic                 eng_finish_i,
  input  logic [RES_W-1:0]     eng_c_matrix_i,
  input  logic [FLG_W-1:0]     eng_flags_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [RES_W-1:0]     c_matrix_o,
  output logic [FLG_W-1:0]     flags_o,
  output logic [1:0]           status_o,
  output logic [CNT_WIDTH-1:0] cycles_o,
  output logic                 busy_o
);

  state_e               state_q;
  status_e              status_q;
  logic                 cmd_ready_q, eng_start_q, res_valid_q, busy_q;
  logic [DIM_WIDTH-1:0] n_q, k_q, m_q;
  logic [MAT_W-1:0]     a_q, b_q;
  logic [RES_W-1:0]     c_q;
  logic [FLG_W-1:0]     flags_q;
  logic [CNT_WIDTH-1:0] cycles_q;

  logic                 dims_bad;
  logic [CNT_WIDTH-1:0] wd_count_next;
  logic                 wd_expired;

  assign dims_bad = dim_invalid(n_dim_i, MAX_DIM) || dim_invalid(k_dim_i, MAX_DIM)
                 || dim_invalid(m_dim_i, MAX_DIM);

  matmul_watchdog #(
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_watchdog (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (state_q == ST_IDLE),
    .en_i         (state_q == ST_RUN),
    .count_next_o (wd_count_next),
    .expired_o    (wd_expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      status_q    <= STATUS_OK;
      cmd_ready_q <= 1'b1;
      eng_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      n_q         <= '0;
      k_q         <= '0;
      m_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      flags_q     <= '0;
      cycles_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            n_q         <= n_dim_i;
            k_q         <= k_dim_i;
            m_q         <= m_dim_i;
            a_q         <= a_matrix_i;
            b_q         <= b_matrix_i;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (dims_bad) begin
              // Rejected commands never start the engine; report straight away.
              state_q     <= ST_DONE;
              status_q    <= STATUS_BAD_DIMS;
              res_valid_q <= 1'b1;
              c_q         <= '0;
              flags_q     <= '0;
              cycles_q    <= '0;
            end else begin
              state_q     <= ST_RUN;
              eng_start_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Finish is checked first so a result arriving on the timeout cycle is kept.
          if (eng_finish_i) begin
            state_q     <= ST_DONE;
            status_q    <= STATUS_OK;
            eng_start_q <= 1'b0;
            res_valid_q <= 1'b1;
            c_q         <= eng_c_matrix_i;
            flags_q     <= eng_flags_i;
            cycles_q    <= wd_count_next;
          end else if (wd_expired) begin
            state_q     <= ST_DONE;
            status_q    <= STATUS_TIMEOUT;
            eng_start_q <= 1'b0;
            res_valid_q <= 1'b1;
            c_q         <= '0;
            flags_q     <= '0;
            cycles_q    <= wd_count_next;
          end
        end
        ST_DONE: begin
          if (res_ready_i) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign eng_start_o    = eng_start_q;
  assign eng_n_dim_o    = n_q;
  assign eng_k_dim_o    = k_q;
  assign eng_m_dim_o    = m_q;
  assign eng_a_matrix_o = a_q;
  assign eng_b_matrix_o = b_q;
  assign res_valid_o    = res_valid_q;
  assign c_matrix_o     = c_q;
  assign flags_o        = flags_q;
  assign status_o       = status_q;
  assign cycles_o       = cycles_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_matmul_ctrl_fsm.sv
// tb/tb_matmul_ctrl_fsm.sv - directed self-checking bench for matmul_ctrl_fsm
module tb_matmul_ctrl_fsm;

  localparam logic [31:0] A1  = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [31:0] B1  = {8'd8, 8'd7, 8'd6, 8'd5};
  localparam logic [63:0] C1  = {16'd50, 16'd43, 16'd22, 16'd19};
  localparam logic [31:0] A2  = 32'h11223344;
  localparam logic [31:0] A6  = 32'h7F7F7F7F;
  localparam logic [63:0] C6  = {4{16'h7E02}};
  localparam logic [31:0] BI  = {8'd1, 8'd0, 8'd0, 8'd1};
  localparam logic [63:0] C6B = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  n_dim, k_dim, m_dim;
  logic [31:0] a_mat, b_mat;
  logic        eng_start;
  logic [2:0]  eng_n, eng_k, eng_m;
  logic [31:0] eng_a, eng_b;
  logic        eng_finish;
  logic [63:0] eng_c;
  logic [3:0]  eng_flags;
  logic        res_valid, res_ready;
  logic [63:0] c_mat;
  logic [3:0]  flags;
  logic [1:0]  status;
  logic [7:0]  cycles;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  matmul_ctrl_fsm dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .n_dim_i(n_dim), .k_dim_i(k_dim), .m_dim_i(m_dim),
    .a_matrix_i(a_mat), .b_matrix_i(b_mat),
    .eng_start_o(eng_start),
    .eng_n_dim_o(eng_n), .eng_k_dim_o(eng_k), .eng_m_dim_o(eng_m),
    .eng_a_matrix_o(eng_a), .eng_b_matrix_o(eng_b),
    .eng_finish_i(eng_finish), .eng_c_matrix_i(eng_c), .eng_flags_i(eng_flags),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .c_matrix_o(c_mat), .flags_o(flags), .status_o(status),
    .cycles_o(cycles), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] n, input logic [2:0] k, input logic [2:0] m,
                          input logic [31:0] a, input logic [31:0] b);
    n_dim = n; k_dim = k; m_dim = m; a_mat = a; b_mat = b;
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; n_dim = '0; k_dim = '0; m_dim = '0; a_mat = '0; b_mat = '0;
    eng_finish = 1'b0; eng_c = '0; eng_flags = '0; res_ready = 1'b0;
    cyc(); cyc();
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    n_total++; if (eng_start !== 1'b0) $display("FAIL reset_start: got %b want 0", eng_start); else n_pass++;
    n_total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else n_pass++;
    n_total++; if ({busy, status, cycles} !== 11'd0) $display("FAIL reset_busy_status_cycles: got %h want 0", {busy, status, cycles}); else n_pass++;
    n_total++; if ({c_mat, flags, eng_a, eng_b} !== 132'd0) $display("FAIL reset_data: got %h want 0", {c_mat, flags, eng_a, eng_b}); else n_pass++;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    eng_c = C1; eng_flags = 4'b0000;
    send_cmd(3'd2, 3'd2, 3'd2, A1, B1);
    n_total++; if (eng_start !== 1'b1) $display("FAIL basic_start: got %b want 1", eng_start); else n_pass++;
    n_total++; if ({cmd_ready, busy} !== 2'b01) $display("FAIL basic_ready_busy: got %b want 01", {cmd_ready, busy}); else n_pass++;
    n_total++; if ({eng_a, eng_b} !== {A1, B1}) $display("FAIL basic_operands: got %h want %h", {eng_a, eng_b}, {A1, B1}); else n_pass++;
    n_total++; if ({eng_n, eng_k, eng_m} !== 9'o222) $display("FAIL basic_dims: got %o want 222", {eng_n, eng_k, eng_m}); else n_pass++;
    cyc(); cyc(); cyc();
    eng_finish = 1'b1;
    cyc();
    eng_finish = 1'b0;
    eng_c = JUNK;
    n_total++; if (res_valid !== 1'b1) $display("FAIL basic_res_valid: got %b want 1", res_valid); else n_pass++;
    n_total++; if (c_mat !== C1) $display("FAIL basic_c: got %h want %h", c_mat, C1); else n_pass++;
    n_total++; if ({flags, status} !== 6'd0) $display("FAIL basic_flags_status: got %h want 0", {flags, status}); else n_pass++;
    n_total++; if (cycles !== 8'd4) $display("FAIL basic_cycles: got %0d want 4", cycles); else n_pass++;
    n_total++; if (eng_start !== 1'b0) $display("FAIL basic_start_drop: got %b want 0", eng_start); else n_pass++;
    cyc();
    n_total++; if (c_mat !== C1) $display("FAIL basic_c_held: got %h want %h", c_mat, C1); else n_pass++;
    release_result();
    n_total++; if ({cmd_ready, res_valid, busy} !== 3'b100) $display("FAIL basic_back_idle: got %b want 100", {cmd_ready, res_valid, busy}); else n_pass++;
  endtask

  task automatic test_bad_dims();
    send_cmd(3'd0, 3'd2, 3'd2, A2, B1);
    n_total++; if ({res_valid, status} !== 3'b101) $display("FAIL bad_n0_done: got %b want 101", {res_valid, status}); else n_pass++;
    n_total++; if (eng_start !== 1'b0) $display("FAIL bad_n0_start: got %b want 0", eng_start); else n_pass++;
    n_total++; if ({c_mat, flags, cycles} !== 76'd0) $display("FAIL bad_n0_zeroed: got %h want 0", {c_mat, flags, cycles}); else n_pass++;
    n_total++; if ({eng_n, eng_a} !== {3'd0, A2}) $display("FAIL bad_n0_latched: got %h want %h", {eng_n, eng_a}, {3'd0, A2}); else n_pass++;
    release_result();
    send_cmd(3'd2, 3'd3, 3'd2, A1, B1);
    n_total++; if ({res_valid, status, eng_start} !== 4'b1010) $display("FAIL bad_k3: got %b want 1010", {res_valid, status, eng_start}); else n_pass++;
    release_result();
  endtask

  task automatic test_timeout();
    int start_low = 0;
    eng_c = JUNK; eng_flags = 4'b1111;
    send_cmd(3'd2, 3'd2, 3'd2, A1, B1);
    for (int i = 0; i < 31; i++) begin
      if (eng_start !== 1'b1) start_low++;
      cyc();
    end
    n_total++; if (start_low !== 0) $display("FAIL timeout_start_held: got %0d low cycles want 0", start_low); else n_pass++;
    n_total++; if ({eng_start, res_valid} !== 2'b10) $display("FAIL timeout_still_run: got %b want 10", {eng_start, res_valid}); else n_pass++;
    cyc();
    n_total++; if ({res_valid, status} !== 3'b110) $display("FAIL timeout_status: got %b want 110", {res_valid, status}); else n_pass++;
    n_total++; if (cycles !== 8'd32) $display("FAIL timeout_cycles: got %0d want 32", cycles); else n_pass++;
    n_total++; if ({eng_start, c_mat, flags} !== 69'd0) $display("FAIL timeout_zeroed: got %h want 0", {eng_start, c_mat, flags}); else n_pass++;
    release_result();
  endtask

  task automatic test_backpressure();
    int unstable = 0;
    eng_c = C1; eng_flags = 4'b0000;
    send_cmd(3'd2, 3'd2, 3'd2, A1, B1);
    eng_finish = 1'b1;
    cyc();
    eng_finish = 1'b0;
    eng_c = JUNK;
    n_dim = 3'd1; k_dim = 3'd1; m_dim = 3'd1; a_mat = A2; b_mat = B1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (res_valid !== 1'b1 || c_mat !== C1 || status !== 2'b00 || cmd_ready !== 1'b0) unstable++;
    end
    n_total++; if (unstable !== 0) $display("FAIL bp_held_stable: got %0d unstable cycles want 0", unstable); else n_pass++;
    n_total++; if (eng_a !== A1) $display("FAIL bp_no_accept: got %h want %h", eng_a, A1); else n_pass++;
    release_result();
    n_total++; if ({cmd_ready, res_valid, eng_a} !== {2'b10, A1}) $display("FAIL bp_idle: got %h want %h", {cmd_ready, res_valid, eng_a}, {2'b10, A1}); else n_pass++;
    cyc();
    cmd_valid = 1'b0;
    n_total++; if ({eng_start, eng_a, eng_n} !== {1'b1, A2, 3'd1}) $display("FAIL bp_second_accept: got %h want %h", {eng_start, eng_a, eng_n}, {1'b1, A2, 3'd1}); else n_pass++;
    eng_finish = 1'b1;
    cyc();
    eng_finish = 1'b0;
    release_result();
  endtask

  task automatic test_finish_at_timeout();
    eng_c = C6B; eng_flags = 4'b0110;
    send_cmd(3'd2, 3'd2, 3'd2, A1, BI);
    for (int i = 0; i < 31; i++) cyc();
    eng_finish = 1'b1;
    cyc();
    eng_finish = 1'b0;
    n_total++; if ({res_valid, status} !== 3'b100) $display("FAIL tie_status: got %b want 100", {res_valid, status}); else n_pass++;
    n_total++; if ({c_mat, flags} !== {C6B, 4'b0110}) $display("FAIL tie_capture: got %h want %h", {c_mat, flags}, {C6B, 4'b0110}); else n_pass++;
    n_total++; if (cycles !== 8'd32) $display("FAIL tie_cycles: got %0d want 32", cycles); else n_pass++;
    release_result();
  endtask

  task automatic test_reset_mid_run();
    send_cmd(3'd2, 3'd2, 3'd2, A1, B1);
    cyc();
    rst_n = 1'b0;
    #1;
    n_total++; if ({eng_start, res_valid, cmd_ready} !== 3'b001) $display("FAIL rst_mid_run: got %b want 001", {eng_start, res_valid, cmd_ready}); else n_pass++;
    #2;
    rst_n = 1'b1;
    cyc();
    n_total++; if ({busy, eng_a, c_mat} !== 97'd0) $display("FAIL rst_discard: got %h want 0", {busy, eng_a, c_mat}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    eng_c = C6; eng_flags = 4'b1010;
    send_cmd(3'd2, 3'd2, 3'd2, A6, A6);
    cyc();
    eng_finish = 1'b1;
    cyc();
    eng_finish = 1'b0;
    n_total++; if ({c_mat, flags} !== {C6, 4'b1010}) $display("FAIL b2b_first: got %h want %h", {c_mat, flags}, {C6, 4'b1010}); else n_pass++;
    release_result();
    eng_c = C6B; eng_flags = 4'b0000;
    send_cmd(3'd2, 3'd2, 3'd2, A1, BI);
    eng_finish = 1'b1;
    cyc();
    eng_finish = 1'b0;
    n_total++; if ({c_mat, flags, status} !== {C6B, 4'b0000, 2'b00}) $display("FAIL b2b_second: got %h want %h", {c_mat, flags, status}, {C6B, 6'd0}); else n_pass++;
    n_total++; if (cycles !== 8'd1) $display("FAIL b2b_cycles: got %0d want 1", cycles); else n_pass++;
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_dims();
    test_timeout();
    test_backpressure();
    test_finish_at_timeout();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
